// File: rtl/scroll_engine.sv
// Memory-fed scrolling window: fetches one symbol per step and shifts it into a DIGITS-wide display.
// Optional macro WRAP_PAUSE_EN adds a HOLD state that pauses PAUSE_STEPS step intervals after each wrap.
module scroll_engine #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned ADDR_W      = 6,
  parameter int unsigned DIV_W       = 24,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned PAUSE_STEPS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     restart,
  input  logic                     dir,
  input  logic [DIV_W-1:0]         rate,
  input  logic [ADDR_W-1:0]        msg_last,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_data,
  output logic [DIGITS*DATA_W-1:0] disp,
  output logic                     step,
  output logic                     wrap,
  output logic                     busy
);

  localparam int unsigned W     = DIGITS * DATA_W;
  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

`ifdef WRAP_PAUSE_EN
  localparam int unsigned HOLD_W = DIV_W + $clog2(PAUSE_STEPS + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_FETCH, S_LAT, S_CAPTURE, S_HOLD
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_FETCH, S_LAT, S_CAPTURE
  } state_t;
`endif

  state_t             state_q;
  logic [W-1:0]       disp_q, disp_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [DIV_W-1:0]   div_q;
  logic [LAT_W-1:0]   lat_q;
  logic               wrap_d;
  logic               mem_en_q, step_q, wrap_q, busy_q;

`ifdef WRAP_PAUSE_EN
  logic [HOLD_W-1:0]  hold_q;
  logic [HOLD_W-1:0]  hold_len;
  logic               hold_done;

  // Pause length tracks the live rate so it always equals PAUSE_STEPS step intervals.
  assign hold_len  = HOLD_W'(PAUSE_STEPS) * (HOLD_W'(rate) + HOLD_W'(1));
  assign hold_done = (hold_q + HOLD_W'(1)) >= hold_len;
`endif

  // Window and pointer values that a CAPTURE would commit this cycle.
  always_comb begin
    disp_d = disp_q;
    ptr_d  = ptr_q;
    wrap_d = 1'b0;
    if (dir) begin
      disp_d = {mem_data, disp_q[W-1:DATA_W]};
      if (ptr_q == '0) begin
        ptr_d  = msg_last;
        wrap_d = 1'b1;
      end else begin
        ptr_d = ptr_q - ADDR_W'(1);
      end
    end else begin
      disp_d = {disp_q[W-DATA_W-1:0], mem_data};
      if (ptr_q >= msg_last) begin
        ptr_d  = '0;
        wrap_d = 1'b1;
      end else begin
        ptr_d = ptr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      disp_q   <= '0;
      ptr_q    <= '0;
      div_q    <= '0;
      lat_q    <= '0;
      mem_en_q <= 1'b0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      busy_q   <= 1'b0;
`ifdef WRAP_PAUSE_EN
      hold_q   <= '0;
`endif
    end else begin
      mem_en_q <= 1'b0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;

      // Restart discards any fetch in flight, so its data never reaches the window.
      if (restart) begin
        disp_q  <= '0;
        div_q   <= '0;
        ptr_q   <= dir ? msg_last : '0;
        state_q <= en ? S_WAIT : S_IDLE;
        busy_q  <= en;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (en) begin
              state_q <= S_WAIT;
              div_q   <= '0;
              busy_q  <= 1'b1;
            end
          end

          S_WAIT: begin
            if (!en) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else if (div_q == rate) begin
              state_q  <= S_FETCH;
              div_q    <= '0;
              mem_en_q <= 1'b1;
            end else begin
              div_q <= div_q + DIV_W'(1);
            end
          end

          S_FETCH: begin
            lat_q <= '0;
            if (RD_LAT > 1) begin
              state_q <= S_LAT;
            end else begin
              state_q <= S_CAPTURE;
            end
          end

          S_LAT: begin
            if (lat_q == LAT_LAST) begin
              state_q <= S_CAPTURE;
            end else begin
              lat_q <= lat_q + LAT_W'(1);
            end
          end

          S_CAPTURE: begin
            disp_q <= disp_d;
            ptr_q  <= ptr_d;
            step_q <= 1'b1;
            wrap_q <= wrap_d;
            div_q  <= '0;
            if (!en) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
`ifdef WRAP_PAUSE_EN
            end else if (wrap_d && (PAUSE_STEPS != 0)) begin
              state_q <= S_HOLD;
              hold_q  <= '0;
`endif
            end else begin
              state_q <= S_WAIT;
            end
          end

`ifdef WRAP_PAUSE_EN
          S_HOLD: begin
            if (!en) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else if (hold_done) begin
              state_q <= S_WAIT;
              div_q   <= '0;
            end else begin
              hold_q <= hold_q + HOLD_W'(1);
            end
          end
`endif

          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_en   = mem_en_q;
  assign mem_addr = ptr_q;
  assign disp     = disp_q;
  assign step     = step_q;
  assign wrap     = wrap_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_scroll_engine.sv
// Testbench for scroll_engine: table vectors, hand-written corner sequences and a
// randomized run checked against a digit-array model of the scrolling window.
module tb_scroll_engine;

  localparam int PAUSE_STEPS = 2;
`ifdef WRAP_PAUSE_EN
  localparam int PAUSE_ON = 1;
`else
  localparam int PAUSE_ON = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        restart = 1'b0;
  logic        dir = 1'b0;
  logic [23:0] rate = '0;
  logic [5:0]  msgLast = '0;
  logic        memEn;
  logic [5:0]  memAddr;
  logic [3:0]  memData = '0;
  logic [31:0] disp;
  logic        step;
  logic        wrap;
  logic        busy;

  int testsRun = 0;
  int testsFailed = 0;
  int cyc = 0;

  scroll_engine #(
    .DIGITS(8), .DATA_W(4), .ADDR_W(6), .DIV_W(24), .RD_LAT(1), .PAUSE_STEPS(PAUSE_STEPS)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .restart(restart), .dir(dir),
    .rate(rate), .msg_last(msgLast), .mem_en(memEn), .mem_addr(memAddr),
    .mem_data(memData), .disp(disp), .step(step), .wrap(wrap), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memory preloaded with mem[i] = i (truncated to the symbol width).
  always @(posedge clk) if (memEn) memData <= memAddr[3:0];

  typedef struct {
    logic [23:0] rate;
    logic [5:0]  ml;
    logic        d;
    int          n;
    logic [31:0] expDisp;
    logic        expWrap;
    logic        prevWrap;
  } vec_t;

  vec_t vecs[7];

  function automatic int pauseCycles(input int r);
    return PAUSE_ON * PAUSE_STEPS * (r + 1);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    testsRun++;
    testsFailed++;
    $display("[TB] FAIL %s: got timeout, expected event", name);
  endtask

  task automatic waitStep(input int budget, output int t, output logic wr, output bit ok);
    int i;
    ok = 0; t = 0; wr = 0; i = 0;
    while (!ok && i < budget) begin
      @(negedge clk);
      i++;
      if (step === 1'b1) begin
        ok = 1; t = cyc; wr = wrap;
      end
    end
  endtask

  task automatic waitMemEn(input int budget, output int t, output bit ok);
    int i;
    ok = 0; t = 0; i = 0;
    while (!ok && i < budget) begin
      @(negedge clk);
      i++;
      if (memEn === 1'b1) begin
        ok = 1; t = cyc;
      end
    end
  endtask

  task automatic applyStimulus(input logic [23:0] r, input logic [5:0] ml, input logic d, output int tRel);
    @(negedge clk);
    rate = r; msgLast = ml; dir = d; en = 1'b1; restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    tRel = cyc;
  endtask

  task automatic countSteps(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (step === 1'b1) cnt++;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got time limit, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t, tPrev, tRel, cnt, r, ml, d, n, ptr;
    int win[8];
    logic wr, lastWr, prevWr;
    bit ok;
    logic [31:0] held, expD;

    vecs[0] = '{24'd0, 6'd3,  1'b0, 4, 32'h0000_0123, 1'b1, 1'b0};
    vecs[1] = '{24'd0, 6'd3,  1'b0, 5, 32'h0000_1230, 1'b0, 1'b1};
    vecs[2] = '{24'd0, 6'd3,  1'b1, 4, 32'h0123_0000, 1'b1, 1'b0};
    vecs[3] = '{24'd4, 6'd3,  1'b0, 2, 32'h0000_0001, 1'b0, 1'b0};
    vecs[4] = '{24'd1, 6'd1,  1'b0, 3, 32'h0000_0010, 1'b0, 1'b1};
    vecs[5] = '{24'd0, 6'd63, 1'b1, 2, 32'hEF00_0000, 1'b0, 1'b0};
    vecs[6] = '{24'd2, 6'd5,  1'b0, 6, 32'h0001_2345, 1'b1, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset_disp", disp, 0);
    checkOutput("reset_mem_en", memEn, 0);
    checkOutput("reset_mem_addr", memAddr, 0);
    checkOutput("reset_step", step, 0);
    checkOutput("reset_wrap", wrap, 0);
    checkOutput("reset_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_busy", busy, 0);

    // Table-driven vectors
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].rate, vecs[v].ml, vecs[v].d, tRel);
      checkOutput($sformatf("v%0d_restart_disp", v), disp, 0);
      tPrev = 0; t = 0; lastWr = 0; ok = 1;
      for (int s = 0; s < vecs[v].n && ok; s++) begin
        tPrev = t;
        waitStep(80, t, lastWr, ok);
        if (!ok) reportTimeout($sformatf("v%0d_step%0d", v, s + 1));
        else if (s == 0) checkOutput($sformatf("v%0d_first_latency", v), t - tRel, vecs[v].rate + 3);
      end
      if (ok) begin
        checkOutput($sformatf("v%0d_disp", v), disp, vecs[v].expDisp);
        checkOutput($sformatf("v%0d_wrap", v), lastWr, vecs[v].expWrap);
        checkOutput($sformatf("v%0d_gap", v), t - tPrev,
                    vecs[v].rate + 3 + (vecs[v].prevWrap ? pauseCycles(int'(vecs[v].rate)) : 0));
        checkOutput($sformatf("v%0d_busy", v), busy, 1);
      end
    end

    // Right scroll: after the wrap the next fetch goes back to msg_last
    applyStimulus(0, 3, 1, tRel);
    for (int s = 0; s < 4; s++) begin
      waitStep(40, t, wr, ok);
      if (!ok) reportTimeout("right_step");
    end
    waitMemEn(40, t, ok);
    if (!ok) reportTimeout("right_refetch");
    else checkOutput("right_refetch_addr", memAddr, 3);

    // en=0 in WAIT: engine idles and the window holds
    applyStimulus(4, 3, 0, tRel);
    waitStep(40, t, wr, ok);
    if (!ok) reportTimeout("enoff_step");
    en = 1'b0;
    held = disp;
    @(negedge clk);
    checkOutput("enoff_busy", busy, 0);
    countSteps(25, cnt);
    checkOutput("enoff_no_step", cnt, 0);
    checkOutput("enoff_disp_held", disp, held);

    // en=0 in the cycle after the fetch strobe: exactly one more step
    applyStimulus(1, 7, 0, tRel);
    waitStep(40, t, wr, ok);
    if (!ok) reportTimeout("late_en_step1");
    waitMemEn(40, t, ok);
    if (!ok) reportTimeout("late_en_fetch");
    @(negedge clk);
    en = 1'b0;
    countSteps(20, cnt);
    checkOutput("late_en_steps", cnt, 1);
    checkOutput("late_en_disp", disp, 32'h0000_0001);
    checkOutput("late_en_busy", busy, 0);

    // Restart coincident with a wrapping CAPTURE: no step, no wrap, cleared window
    applyStimulus(0, 2, 1, tRel);
    for (int s = 0; s < 2; s++) begin
      waitStep(40, t, wr, ok);
      if (!ok) reportTimeout("rs_step");
    end
    checkOutput("rs_disp_before", disp, 32'h1200_0000);
    waitMemEn(40, t, ok);
    if (!ok) reportTimeout("rs_fetch");
    checkOutput("rs_fetch_addr", memAddr, 0);
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checkOutput("rs_step", step, 0);
    checkOutput("rs_wrap", wrap, 0);
    checkOutput("rs_disp", disp, 0);

    // msg_last lowered below the pointer: the next left step wraps
    applyStimulus(0, 9, 0, tRel);
    for (int s = 0; s < 5; s++) begin
      waitStep(40, t, wr, ok);
      if (!ok) reportTimeout("lower_step");
    end
    msgLast = 6'd2;
    waitStep(40, t, wr, ok);
    if (!ok) reportTimeout("lower_wrap_step");
    else begin
      checkOutput("lower_wrap", wr, 1);
      checkOutput("lower_disp", disp, 32'h0001_2345);
    end
    waitMemEn(40, t, ok);
    if (!ok) reportTimeout("lower_refetch");
    else checkOutput("lower_refetch_addr", memAddr, 0);

    // Asynchronous reset in the middle of a fetch, then release with en=1
    applyStimulus(2, 7, 0, tRel);
    for (int s = 0; s < 2; s++) begin
      waitStep(40, t, wr, ok);
      if (!ok) reportTimeout("areset_step");
    end
    waitMemEn(40, t, ok);
    if (!ok) reportTimeout("areset_fetch");
    #1 reset = 1'b0;
    #1;
    checkOutput("areset_disp", disp, 0);
    checkOutput("areset_mem_en", memEn, 0);
    checkOutput("areset_step", step, 0);
    checkOutput("areset_busy", busy, 0);
    @(negedge clk);
    en = 1'b1;
    reset = 1'b1;
    tRel = cyc;
    waitMemEn(40, t, ok);
    if (!ok) reportTimeout("areset_first_fetch");
    else begin
      checkOutput("areset_first_fetch_delay", t - tRel, 2 + 2);
      checkOutput("areset_first_addr", memAddr, 0);
    end

    // Randomized runs against a digit-array model of the window
    for (int trial = 0; trial < 15; trial++) begin
      r  = int'($urandom_range(0, 3));
      ml = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 63));
      d  = int'($urandom_range(0, 1));
      n  = int'($urandom_range(2, 12));
      for (int i = 0; i < 8; i++) win[i] = 0;
      ptr = (d == 1) ? ml : 0;
      prevWr = 0;
      t = 0;
      applyStimulus(r[23:0], ml[5:0], d[0], tRel);
      ok = 1;
      for (int s = 0; s < n && ok; s++) begin
        tPrev = t;
        waitStep(r + 3 + pauseCycles(r) + 20, t, wr, ok);
        if (!ok) begin
          reportTimeout($sformatf("rnd%0d_step%0d", trial, s + 1));
        end else begin
          if (d == 0) begin
            for (int i = 7; i > 0; i--) win[i] = win[i-1];
            win[0] = ptr % 16;
            lastWr = (ptr >= ml);
            ptr = lastWr ? 0 : ptr + 1;
          end else begin
            for (int i = 0; i < 7; i++) win[i] = win[i+1];
            win[7] = ptr % 16;
            lastWr = (ptr == 0);
            ptr = lastWr ? ml : ptr - 1;
          end
          expD = '0;
          for (int i = 0; i < 8; i++) expD = expD | (32'(win[i]) << (4 * i));
          checkOutput($sformatf("rnd%0d_s%0d_disp", trial, s + 1), disp, expD);
          checkOutput($sformatf("rnd%0d_s%0d_wrap", trial, s + 1), wr, lastWr);
          if (s == 0)
            checkOutput($sformatf("rnd%0d_latency", trial), t - tRel, r + 3);
          else
            checkOutput($sformatf("rnd%0d_s%0d_gap", trial, s + 1), t - tPrev,
                        r + 3 + (prevWr ? pauseCycles(r) : 0));
          prevWr = lastWr;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
